// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-parameter macros, arbiter state encoding and defaults.
`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif
`ifndef BAUD_RATE_p
`define BAUD_RATE_p 115200
`endif
`ifndef CLOCK_FREQ_p
`define CLOCK_FREQ_p 50000000
`endif

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } tx_arb_state_t;

  localparam int TX_ACCEPT_TIMEOUT_DEF = 16;

  // Modulo-n increment that does not rely on power-of-two wrap.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, searching upward with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        win[idx] = 1'b1;
        win_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ clients; latches the
// winner's word, strobes the transmitter, re-strobes on a missed accept, reports done.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORD_SIZE      = `WORD_SIZE_p,
  parameter int ACCEPT_TIMEOUT = TX_ACCEPT_TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WORD_SIZE-1:0] data_in,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [WORD_SIZE-1:0]         data_send,
  output logic                         tx_send_o,
  input  logic                         tx_avbl_i
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(ACCEPT_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACCEPT_TIMEOUT - 1);

  tx_arb_state_t        state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 send_q, send_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   win;
  logic [PW-1:0]        win_idx;
  logic                 any_req;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    gnt_d   = '0;
    done_d  = '0;
    send_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_avbl_i && any_req) begin
          data_d  = data_in[int'(win_idx)*WORD_SIZE +: WORD_SIZE];
          owner_d = win_idx;
          gnt_d   = win;
          send_d  = 1'b1;
          ptr_d   = PW'(next_idx(int'(win_idx), NUM_REQ));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!tx_avbl_i) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Transmitter missed the strobe: repeat it for the same owner, no new grant.
          send_d  = 1'b1;
          state_d = ISSUE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_avbl_i) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign data_send = data_q;
  assign tx_send_o = send_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` requesters. It latches the winning requester's word and pulses the transmitter's send strobe. It holds `data_send` stable for the whole frame and reports frame completion back to the owning requester. It sits between client logic (command responders, status reporters) and `UART_TRANSMITTER`, and drives that block's `data_send` / `tx_send_i` while observing `tx_avbl_i`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WORD_SIZE`, `` `WORD_SIZE_p ``: frame payload width, matching the transmitter.
- `ACCEPT_TIMEOUT`, 16: cycles to wait in WAIT_ACCEPT for `tx_avbl_i` to fall before re-issuing the send strobe, ≥2.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in NUM_REQ: per-requester request level; held with its data until granted.
- `data_in` in NUM_REQ*WORD_SIZE: flattened words; requester i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- `gnt` out NUM_REQ: one-hot, 1-cycle pulse; the word has been latched and the requester may drop `req` or change its data.
- `done` out NUM_REQ: one-hot, 1-cycle pulse; the owner's frame has fully left the transmitter.
- `busy` out 1: high whenever state ≠ IDLE.
- `data_send` out WORD_SIZE: to transmitter `data_send`.
- `tx_send_o` out 1: to transmitter `tx_send_i`.
- `tx_avbl_i` in 1: from transmitter `tx_avbl_i`.

## Operation
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE.
- IDLE: when `tx_avbl_i` and `|req`:
  - Pick winner w as the first asserted `req` at or after `ptr`, searching upward with wrap.
  - `data_reg` ← word w, `owner` ← w, `gnt[w]` ← 1, `tx_send_o` ← 1, `ptr` ← (w+1) mod NUM_REQ, state → ISSUE.
  - With no request, or with `tx_avbl_i` low, stay in IDLE.
- ISSUE: `tx_send_o` ← 0, `tmo_cnt` ← 0, state → WAIT_ACCEPT.
- WAIT_ACCEPT:
  - If `!tx_avbl_i`, the transmitter has accepted; state → WAIT_DONE.
  - Otherwise `tmo_cnt`++. When `tmo_cnt` == ACCEPT_TIMEOUT-1, `tx_send_o` ← 1 and state → ISSUE (re-strobe with the same owner and data, no new `gnt`).
- WAIT_DONE: when `tx_avbl_i` rises, `done[owner]` ← 1 and state → IDLE.
- `data_send` = `data_reg` and stays constant from the ISSUE cycle until the `done` pulse.
- Requests arriving outside IDLE wait. `req` is not latched; a requester that drops `req` before being granted is simply skipped.
- `ptr` advances only on grant, so every continuously asserted requester is served within NUM_REQ frames.
- Widths:
  - `ptr` and `owner` are $clog2(NUM_REQ) bits; the wrap is explicit and does not rely on power-of-two overflow.
  - `tmo_cnt` is $clog2(ACCEPT_TIMEOUT) bits.

## Timing
- Reset:
  - `gnt`=0, `done`=0, `busy`=0, `tx_send_o`=0, `data_send`=0.
  - `ptr`=0, `owner`=0, `tmo_cnt`=0, state=IDLE.
  - The reset value takes effect on the first clk edge with `rst` high.
- Reset mid-frame: the same values apply. Any pending `done` is lost. The transmitter is expected to be reset on the same `rst`.
- All outputs are registered.
- Grant latency: `req` and `tx_avbl_i` are sampled high at edge N; `gnt` and `tx_send_o` are high in cycle N+1.
- `tx_send_o` is high for exactly one cycle per strobe and is never high outside ISSUE.
- `tx_avbl_i` is expected low in the cycle after ISSUE. The timeout path covers a transmitter that misses the strobe.
- Completion latency: `tx_avbl_i` is sampled high in WAIT_DONE at edge M; `done` is high in cycle M+1, together with `busy`=0.
- The earliest next grant follows at edge M+1 (visible in cycle M+2), so back-to-back frames have a one-cycle arbitration gap plus the transmitter's own inter-frame gap.
- When `done` for requester a and `gnt` for requester b would fall in the same cycle, this cannot occur; the two are always ≥1 cycle apart.

## Structure
- Shared package `uart_pkg`:
  - `tx_arb_state_t` enum (IDLE/ISSUE/WAIT_ACCEPT/WAIT_DONE).
  - Default `ACCEPT_TIMEOUT`.
  - The existing `WORD_SIZE_p` / `BAUD_RATE_p` / `CLOCK_FREQ_p` macros stay the single source for frame parameters.
- Sub-module `rr_pick`: purely combinational, inputs `req` and `ptr`, outputs one-hot `win` and index `win_idx` plus `any`. The FSM, data register and counters stay in `uart_tx_arbiter`.

## Test plan
- Single request: NUM_REQ=4, `req`=4'b0100, `data_in[2]`=8'hA5 → `gnt`=4'b0100 for one cycle, one `tx_send_o` pulse, serial line carries A5, then `done`=4'b0100 once, `busy` returns to 0.
- All requesting continuously (words 11,22,33,44 from ptr=0) → grant order 0,1,2,3,0; serial order 11,22,33,44,11; exactly one `done` per `gnt`.
- Data stability: change `data_in[1]` from 8'h3C to 8'hFF on the cycle after `gnt[1]` → `data_send` holds 3C until `done[1]`; the line carries 3C.
- Timeout: the bench model holds `tx_avbl_i`=1 and ignores the first strobe → after ACCEPT_TIMEOUT cycles, a second `tx_send_o` pulse with the same data; no second `gnt`.
- Reset mid-frame: assert `rst` during WAIT_DONE → next cycle all outputs are 0, state IDLE, `ptr`=0; no `done` pulse; a new request is granted normally afterward.
- Late-arriving request skipped: `req[3]` drops before IDLE re-arbitrates and `req[0]` is high with ptr=3 → `gnt`=4'b0001 and `ptr` becomes 1.
